stim_sig_engine: RTL and testbench

//  Synthesisable successor to the LCG stimulus driver: produces IN_W-bit vectors for a DUT and

---
 rtl/stim_pkg.sv | 27 ++
 rtl/stim_misr.sv | 55 +++++
 rtl/stim_sig_engine.sv | 186 ++++++++++++++++++
 tb/tb_stim_sig_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types and LCG helper for the stimulus/signature engine.
package stim_pkg;

  typedef enum logic [1:0] {
    ModeRand = 2'd0,
    ModeHold = 2'd1,
    ModeWalk = 2'd2,
    ModeIncr = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StApply,
    StCapt,
    StDone
  } state_e;

  localparam logic [31:0] LcgMul = 32'h41C64E6D;
  localparam logic [31:0] LcgInc = 32'h0000_3039;

  // One LCG step, modulo 2^32.
  function automatic logic [31:0] lcg_next(input logic [31:0] cur);
    return cur * LcgMul + LcgInc;
  endfunction

endpackage

// File: rtl/stim_misr.sv
// MISR: folds a wide response into SIG_W bits and shifts it into the signature.
module stim_misr
  import stim_pkg::*;
#(
  parameter int unsigned SIG_W = 32,
  parameter int unsigned OUT_W = 159,
  parameter logic [31:0] POLY  = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [OUT_W-1:0] data_i,
  output logic [SIG_W-1:0] sig_o
);

  localparam int unsigned NSlice = (OUT_W + SIG_W - 1) / SIG_W;
  localparam logic [SIG_W-1:0] PolyW = SIG_W'(POLY);

  logic [NSlice*SIG_W-1:0] padded;
  logic [SIG_W-1:0]        fold;
  logic [SIG_W-1:0]        sig_d, sig_q;

  // Zero-pad the response to whole slices and XOR the slices together.
  always_comb begin
    padded              = '0;
    padded[OUT_W-1:0]   = data_i;
    fold                = '0;
    for (int unsigned i = 0; i < NSlice; i++) begin
      fold = fold ^ padded[i*SIG_W +: SIG_W];
    end
  end

  // Clear wins over a capture so a new run always starts from zero.
  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = (sig_q << 1) ^ (sig_q[SIG_W-1] ? PolyW : '0) ^ fold;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/stim_sig_engine.sv
// Stimulus generator (LCG / hold / walking one / increment) with MISR response compaction.
module stim_sig_engine
  import stim_pkg::*;
#(
  parameter int unsigned IN_W    = 138,
  parameter int unsigned OUT_W   = 159,
  parameter int unsigned SIG_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] SEED    = 32'hD977E993,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned CAP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  input  logic [1:0]       mode_i,
  input  logic [31:0]      seed_i,
  input  logic             seed_load_i,
  input  logic [OUT_W-1:0] dut_out_i,
  output logic [IN_W-1:0]  stim_o,
  output logic             stim_vld_o,
  output logic [SIG_W-1:0] sig_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned NChunk = (IN_W + 31) / 32;
  localparam int unsigned KW     = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam int unsigned CapW   = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;
  localparam int unsigned WalkW  = (IN_W > 1) ? $clog2(IN_W) : 1;
  // Shadow holds every chunk but the last; the last comes straight from the LCG.
  localparam int unsigned ShW    = (NChunk > 1) ? (NChunk - 1) * 32 : 1;
  localparam int unsigned LastW  = IN_W - 32 * (NChunk - 1);

  localparam logic [KW-1:0]    KLast    = KW'(NChunk - 1);
  localparam logic [CapW-1:0]  CapLast  = CapW'(CAP_LAT - 1);
  localparam logic [WalkW-1:0] WalkLast = WalkW'(IN_W - 1);

  state_e            state_d, state_q;
  mode_e             mode_d, mode_q;
  logic [31:0]       lcg_d, lcg_q, lcg_new;
  logic [ShW-1:0]    shadow_d, shadow_q;
  logic [IN_W-1:0]   stim_d, stim_q, rand_vec;
  logic [CNT_W-1:0]  vec_cnt_d, vec_cnt_q;
  logic [CNT_W-1:0]  num_vec_d, num_vec_q;
  logic [KW-1:0]     k_d, k_q;
  logic [CapW-1:0]   cap_d, cap_q;
  logic [WalkW-1:0]  walk_d, walk_q;
  logic              misr_en, misr_clr;

  assign lcg_new = lcg_next(lcg_q);

  if (NChunk > 1) begin : g_multi
    assign rand_vec = {lcg_new[LastW-1:0], shadow_q};
  end else begin : g_single
    assign rand_vec = lcg_new[IN_W-1:0];
  end

  // Next-state logic: FSM, LCG, shadow fill, vector load and counters.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lcg_d     = lcg_q;
    shadow_d  = shadow_q;
    stim_d    = stim_q;
    vec_cnt_d = vec_cnt_q;
    num_vec_d = num_vec_q;
    k_d       = k_q;
    cap_d     = cap_q;
    walk_d    = walk_q;
    misr_en   = 1'b0;
    misr_clr  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // Seed loads before the start decision so a same-cycle start uses it.
        if (seed_load_i) begin
          lcg_d = seed_i;
        end
        if (start_i) begin
          num_vec_d = num_vec_i;
          mode_d    = mode_e'(mode_i);
          vec_cnt_d = '0;
          shadow_d  = '0;
          k_d       = '0;
          walk_d    = '0;
          misr_clr  = 1'b1;
          state_d   = (num_vec_i == '0) ? StDone : StFill;
        end
      end

      StFill: begin
        if (mode_q == ModeRand) begin
          lcg_d = lcg_new;
          for (int unsigned c = 0; c + 1 < NChunk; c++) begin
            if (k_q == KW'(c)) begin
              shadow_d[c*32 +: 32] = lcg_new;
            end
          end
        end
        k_d = k_q + KW'(1);
        // The vector is registered on the edge into APPLY so that stim_o and
        // stim_vld_o are valid together during the APPLY cycle.
        if (k_q == KLast) begin
          k_d       = '0;
          state_d   = StApply;
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          unique case (mode_q)
            ModeRand: stim_d = rand_vec;
            ModeHold: stim_d = stim_q;
            ModeWalk: begin
              stim_d = IN_W'(1) << walk_q;
              walk_d = (walk_q == WalkLast) ? '0 : walk_q + WalkW'(1);
            end
            ModeIncr: stim_d = stim_q + IN_W'(1);
          endcase
        end
      end

      StApply: begin
        cap_d   = '0;
        state_d = StCapt;
      end

      StCapt: begin
        cap_d = cap_q + CapW'(1);
        if (cap_q == CapLast) begin
          misr_en = 1'b1;
          k_d     = '0;
          state_d = (vec_cnt_q == num_vec_q) ? StDone : StFill;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= ModeRand;
      lcg_q     <= SEED;
      shadow_q  <= '0;
      stim_q    <= '0;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      k_q       <= '0;
      cap_q     <= '0;
      walk_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lcg_q     <= lcg_d;
      shadow_q  <= shadow_d;
      stim_q    <= stim_d;
      vec_cnt_q <= vec_cnt_d;
      num_vec_q <= num_vec_d;
      k_q       <= k_d;
      cap_q     <= cap_d;
      walk_q    <= walk_d;
    end
  end

  stim_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (misr_en),
    .clr_i  (misr_clr),
    .data_i (dut_out_i),
    .sig_o  (sig_o)
  );

  assign stim_o     = stim_q;
  assign vec_cnt_o  = vec_cnt_q;
  assign stim_vld_o = (state_q == StApply);
  assign busy_o     = (state_q == StFill) || (state_q == StApply) || (state_q == StCapt);
  assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_stim_sig_engine.sv
// Directed bench for stim_sig_engine with an expected-vector scoreboard.
module tb_stim_sig_engine;

  localparam int unsigned IN_W    = 138;
  localparam int unsigned OUT_W   = 159;
  localparam int unsigned SIG_W   = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned CAP_LAT = 1;
  localparam int unsigned NCHUNK  = 5;
  localparam int          PERIOD  = NCHUNK + 1 + CAP_LAT;
  localparam logic [31:0] SEED    = 32'hD977E993;
  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [1:0]  M_RAND = 2'd0, M_HOLD = 2'd1, M_WALK = 2'd2, M_INCR = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             seed_load = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic [1:0]       mode = 2'd0;
  logic [31:0]      seed = '0;
  logic [OUT_W-1:0] dut_out;
  logic [IN_W-1:0]  stim;
  logic             stim_vld;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] vec_cnt;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_pass = 0;
  int dsel   = 0;

  logic [31:0]     m_lcg  = SEED;
  logic [IN_W-1:0] m_stim = '0;
  logic [IN_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  stim_sig_engine u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .num_vec_i   (num_vec),
    .mode_i      (mode),
    .seed_i      (seed),
    .seed_load_i (seed_load),
    .dut_out_i   (dut_out),
    .stim_o      (stim),
    .stim_vld_o  (stim_vld),
    .sig_o       (sig),
    .vec_cnt_o   (vec_cnt),
    .busy_o      (busy),
    .done_o      (done)
  );

  function automatic logic [OUT_W-1:0] m_resp(input logic [IN_W-1:0] v);
    case (dsel)
      0:       return '0;
      1:       return OUT_W'(1);
      default: return {v, v[20:0]} ^ OUT_W'(32'hA5A5_0F0F);
    endcase
  endfunction

  // Stand-in DUT: response is a fixed function of the applied vector.
  always_comb dut_out = m_resp(stim);

  function automatic logic [31:0] m_step(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h3039;
  endfunction

  function automatic logic [SIG_W-1:0] m_misr(input logic [SIG_W-1:0] s,
                                              input logic [OUT_W-1:0] d);
    logic [SIG_W-1:0] f;
    f = '0;
    for (int i = 0; i < OUT_W; i++) f[i % SIG_W] = f[i % SIG_W] ^ d[i];
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every stim_vld_o pulse must match the next expected vector.
  always @(negedge clk) begin
    if (rst_n && stim_vld) begin
      chk("vld_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("stim_vec", stim, exp_q.pop_front());
    end
  end

  // One complete run: model the vectors and signature, drive start, wait for DONE.
  task automatic run(input int nv, input logic [1:0] md, input logic sl,
                     input logic [31:0] sv, input logic poke, input string tag);
    logic [IN_W-1:0]  v;
    logic [SIG_W-1:0] s;
    int t, first, bound;
    s = '0;
    if (sl) m_lcg = sv;
    for (int i = 0; i < nv; i++) begin
      v = '0;
      case (md)
        M_RAND: begin
          for (int c = 0; c < NCHUNK; c++) begin
            m_lcg = m_step(m_lcg);
            for (int b = 0; b < 32; b++) if (c * 32 + b < IN_W) v[c*32+b] = m_lcg[b];
          end
        end
        M_HOLD:  v = m_stim;
        M_WALK:  v = IN_W'(1) << (i % IN_W);
        default: v = m_stim + 1'b1;
      endcase
      m_stim = v;
      exp_q.push_back(v);
      s = m_misr(s, m_resp(v));
    end
    num_vec   = CNT_W'(nv);
    mode      = md;
    seed_load = sl;
    seed      = sv;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    t = 0;
    first = -1;
    bound = nv * PERIOD + 20;
    while (!done && t < bound) begin
      if (poke && t == 2) begin
        start = 1'b1; seed_load = 1'b1; seed = 32'h1234_5678; num_vec = 7;
      end
      tick();
      start = 1'b0; seed_load = 1'b0;
      t++;
      if (stim_vld && first < 0) first = t;
    end
    chk({tag, "_cycles"}, t, nv * PERIOD);
    chk({tag, "_first_vld"}, first, (nv == 0) ? -1 : NCHUNK);
    chk({tag, "_sig"}, sig, s);
    chk({tag, "_vec_cnt"}, vec_cnt, nv);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_stim", stim, 0);
    chk("rst_sig", sig, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_vld", stim_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // LCG from the reset seed, chunk order low first.
    dsel = 2;
    run(3, M_RAND, 1'b0, 32'h0, 1'b0, "rand3");
    chk("rand3_done", done, 1);

    // Same-cycle seed load of 0 and start: known first two chunks.
    run(1, M_RAND, 1'b1, 32'h0, 1'b0, "rand_seed0");
    chk("rand_seed0_lo64", stim[63:0], 64'hD3DC167E_00003039);

    dsel = 0;
    run(4, M_WALK, 1'b0, 32'h0, 1'b0, "walk4_zero");
    chk("zero_resp_sig", sig, 32'h0);

    dsel = 1;
    run(2, M_HOLD, 1'b0, 32'h0, 1'b0, "hold2_one");
    chk("one_resp_sig", sig, 32'h3);

    // Walking one wraps past IN_W.
    dsel = 2;
    run(IN_W + 2, M_WALK, 1'b0, 32'h0, 1'b0, "walk_wrap");
    chk("walk_wrap_last", stim, 2);

    // Asynchronous reset in the middle of FILL.
    num_vec = 5; mode = M_RAND; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_stim", stim, 0);
    chk("midrst_sig", sig, 0);
    chk("midrst_vec_cnt", vec_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    #2;
    rst_n  = 1'b1;
    m_lcg  = SEED;
    m_stim = '0;
    tick();

    run(3, M_INCR, 1'b0, 32'h0, 1'b0, "incr3");
    chk("incr3_last", stim, 3);

    // start/seed_load while busy are ignored.
    run(2, M_RAND, 1'b0, 32'h0, 1'b1, "busy_poke");

    // Empty run: DONE next cycle, no vector, stim_o held.
    run(0, M_RAND, 1'b0, 32'h0, 1'b0, "nv0");
    chk("nv0_done", done, 1);

    // Back-to-back runs continue the LCG sequence.
    run(2, M_RAND, 1'b0, 32'h0, 1'b0, "b2b_a");
    run(2, M_RAND, 1'b0, 32'h0, 1'b0, "b2b_b");

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
